fft_sdf_stage: RTL and testbench
================================

FFT_SDF_STAGE -- requirements
Module: fft_sdf_stage

Interface
REQ-001 The block SHALL have parameter STAGE, default 0, giving the butterfly stage index 0..5 and the delay depth D = 32 >> STAGE.
REQ-002 The block SHALL have parameter N_FFT, default 64, giving the transform length; only 64 is supported.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  data_in carries a sample this cycle.
REQ-006 data_in  input  32  natural-order complex sample {re[31:16], im[15:0]}, each field two's complement.
REQ-007 data_out  output  32  DIF-stage result, same packing as data_in, registered.
REQ-008 out_valid  output  1  data_out is valid this cycle, registered.

Function
REQ-009 The block SHALL implement one radix-2 decimation-in-frequency single-path delay-feedback stage, feeding the next stage or the bit-reverse reorder stage.
- Delay line: exactly D words.
- Counter cnt: log2(2D) bits; advances by 1 only on each accepted sample (in_valid=1); wraps 2D-1 -> 0.
REQ-010 Phase A (cnt < D) SHALL push data_in into the delay line and pop the oldest word t; the output candidate is t * W64^((cnt mod D) * 2^STAGE).
REQ-011 Phase B (cnt >= D) SHALL pop the delayed word a and take b = data_in.
- Output candidate: (a + b) >>> 1.
- Pushed into the delay line: (a - b) >>> 1.
- Arithmetic: 17-bit intermediates, arithmetic shift, truncating.
REQ-012 Twiddles SHALL be Q1.14 signed 16-bit values cos/-sin(2*pi*m/64), m = 0..31, held in a 32-entry ROM.
- Complex product: full 32-bit partial products.
- Result: scaled >>> 14 and saturated to [-32768, 32767] per field.
REQ-013 data_out/out_valid SHALL register the candidate one cycle after the accepting edge; latency is 1 cycle from acceptance.
REQ-014 out_valid SHALL be 0 for accepted samples in the first phase A after reset.
- Flag primed sets at the first phase-B acceptance and is never cleared except by reset.
- Once primed, every accepted sample yields exactly one out_valid pulse.
REQ-015 When in_valid=0, cnt, the delay line and primed SHALL hold, out_valid SHALL be 0 next cycle, and data_out SHALL hold its last value.
REQ-016 The last frame's phase-A outputs SHALL appear only as the next frame's samples (or zero-padding with in_valid=1) are accepted; no internal flush exists.
REQ-017 Frames SHALL be back-to-back with no gap cycle required between frames.

Reset
REQ-018 rst=1 SHALL set cnt=0, primed=0, out_valid=0 and data_out=0 on the next edge, mid-frame included; the next accepted sample is index 0.
REQ-019 Delay-line contents SHALL NOT be reset; they SHALL never reach data_out while primed=0.

Configuration
REQ-020 With SDF_ROUND_EN defined, the butterfly >>>1 and the twiddle >>>14 SHALL add half an LSB before shifting (round half up); without it, they SHALL truncate.

Structure
REQ-021 Package fft_pkg SHALL hold N_FFT=64, LOG2N=6, cplx_t (packed struct re/im 16-bit) and the 32-entry twiddle ROM constant.
REQ-022 Complex multiply plus scale/saturate SHALL be sub-module fft_cmult (combinational, 32-bit in x2, 32-bit out).

Verification
REQ-023 The bench SHALL cover these scenarios for STAGE=0, continuous in_valid:
- Impulse: x[0]=0x4000_0000, others 0, two frames. Outputs: index 32 -> 0x2000_0000; other frame-1 phase-B outputs 0; next frame index 0 -> 0x2000_0000.
- DC: all re=1000, im=0. Every primed phase-B output is 0x03E8_0000; every phase-A output is 0.
- Twiddle: x[1]=0x4000_0000, x[33]=0. Next frame index-1 output re=8152 (truncating) or 8153 (SDF_ROUND_EN), im=-803.
- Saturation: x[k]=0x7FFF_7FFF, x[k+32]=0x8000_8000 at k=8, W=(11585,-11585). Re saturates to 32767, no wrap.
- Stall: random in_valid gaps. The output stream equals the gap-free run, and out_valid never asserts on gap cycles.
- Reset at cnt=17, then a fresh impulse frame. No out_valid until index 32; the impulse result matches the Impulse scenario.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, twiddle ROM and fixed-point helpers for the 64-point radix-2 SDF FFT.
// SDF_ROUND_EN selects round-half-up instead of truncation in the butterfly and twiddle scaling.
package fft_pkg;

    localparam int N_FFT = 64;
    localparam int LOG2N = 6;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // W64^m = cos(2*pi*m/64) - j*sin(2*pi*m/64), Q1.14
    localparam cplx_t TW_ROM [32] = '{
        '{ 16'sd16384,   16'sd0    }, '{ 16'sd16305, -16'sd1606  },
        '{ 16'sd16069,  -16'sd3196 }, '{ 16'sd15679, -16'sd4756  },
        '{ 16'sd15137,  -16'sd6270 }, '{ 16'sd14449, -16'sd7723  },
        '{ 16'sd13623,  -16'sd9102 }, '{ 16'sd12665, -16'sd10394 },
        '{ 16'sd11585, -16'sd11585 }, '{ 16'sd10394, -16'sd12665 },
        '{ 16'sd9102,  -16'sd13623 }, '{ 16'sd7723,  -16'sd14449 },
        '{ 16'sd6270,  -16'sd15137 }, '{ 16'sd4756,  -16'sd15679 },
        '{ 16'sd3196,  -16'sd16069 }, '{ 16'sd1606,  -16'sd16305 },
        '{ 16'sd0,     -16'sd16384 }, '{ -16'sd1606, -16'sd16305 },
        '{ -16'sd3196, -16'sd16069 }, '{ -16'sd4756, -16'sd15679 },
        '{ -16'sd6270, -16'sd15137 }, '{ -16'sd7723, -16'sd14449 },
        '{ -16'sd9102, -16'sd13623 }, '{ -16'sd10394, -16'sd12665 },
        '{ -16'sd11585, -16'sd11585 }, '{ -16'sd12665, -16'sd10394 },
        '{ -16'sd13623, -16'sd9102 }, '{ -16'sd14449, -16'sd7723 },
        '{ -16'sd15137, -16'sd6270 }, '{ -16'sd15679, -16'sd4756 },
        '{ -16'sd16069, -16'sd3196 }, '{ -16'sd16305, -16'sd1606 }
    };

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'sh7FFF;
        if (v < -33'sd32768)
            return 16'sh8000;
        return v[15:0];
    endfunction

    // Butterfly halving of a 17-bit sum/difference.
    function automatic logic signed [15:0] half17(input logic signed [16:0] v);
`ifdef SDF_ROUND_EN
        logic [17:0] r;
        r = {v[16], v} + 18'd1;
        // only +65535 can round past the 16-bit range
        return (v == 17'sh0FFFF) ? 16'sh7FFF : r[16:1];
`else
        return v[16:1];
`endif
    endfunction

endpackage

// File: rtl/fft_cmult.sv
// Combinational complex multiply by a Q1.14 twiddle, scaled >>>14 and saturated per field.
// SDF_ROUND_EN adds half an LSB before the shift; zero latency, no flow control.
module fft_cmult
    import fft_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] w,
    output logic [31:0] y
);

`ifdef SDF_ROUND_EN
    localparam logic signed [32:0] BIAS = 33'sd8192;
`else
    localparam logic signed [32:0] BIAS = 33'sd0;
`endif

    cplx_t              av, wv, yv;
    logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [32:0] re_acc, im_acc;

    assign av = a;
    assign wv = w;

    assign p_rr = av.re * wv.re;
    assign p_ii = av.im * wv.im;
    assign p_ri = av.re * wv.im;
    assign p_ir = av.im * wv.re;

    assign re_acc = 33'(p_rr) - 33'(p_ii) + BIAS;
    assign im_acc = 33'(p_ri) + 33'(p_ir) + BIAS;

    assign yv.re = sat16(re_acc >>> 14);
    assign yv.im = sat16(im_acc >>> 14);
    assign y     = yv;

endmodule

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback stage, 1-cycle registered latency from acceptance.
// No backpressure: in_valid gaps freeze all state; SDF_ROUND_EN enables rounding in the arithmetic.
module fft_sdf_stage
    import fft_pkg::*;
#(
    parameter int STAGE = 0,
    parameter int N_FFT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        out_valid
);

    localparam int D  = (N_FFT / 2) >> STAGE;
    localparam int CW = $clog2(2 * D);
    localparam int TW = LOG2N - 1;

    cplx_t             dline [D];
    logic [CW-1:0]     cnt;
    logic [LOG2N-1:0]  cnt_w;
    logic [TW-1:0]     tw_idx;
    logic              primed;
    logic              phase_b;
    logic              emit;
    cplx_t             din, oldest, tw, prod, cand, push;

    assign din     = data_in;
    assign oldest  = dline[D-1];
    assign phase_b = cnt[CW-1];
    assign cnt_w   = LOG2N'(cnt);
    assign tw_idx  = TW'((cnt_w & LOG2N'(D - 1)) << STAGE);
    assign tw      = TW_ROM[tw_idx];

    fft_cmult u_cmult (
        .a (oldest),
        .w (tw),
        .y (prod)
    );

    always_comb begin
        cand = prod;
        push = din;
        if (phase_b) begin
            cand.re = half17(17'(oldest.re) + 17'(din.re));
            cand.im = half17(17'(oldest.im) + 17'(din.im));
            push.re = half17(17'(oldest.re) - 17'(din.re));
            push.im = half17(17'(oldest.im) - 17'(din.im));
        end
    end

    // Outputs only once the delay line holds data from this run.
    assign emit = in_valid & (primed | phase_b);

    always_ff @(posedge clk) begin
        if (in_valid) begin
            dline[0] <= push;
            for (int i = 1; i < D; i++)
                dline[i] <= dline[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= emit;
            if (emit)
                data_out <= cand;
            if (in_valid) begin
                cnt <= cnt + 1'b1;
                if (phase_b)
                    primed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage (STAGE=0): impulse, DC, twiddle, saturation, stalls, mid-frame reset.
module tb_fft_sdf_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        out_valid;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] last_exp = 32'h0;

`ifdef SDF_ROUND_EN
    localparam logic [31:0] EXP_TW1     = 32'h1FD9_FCDD;
    localparam logic [31:0] EXP_TW5     = 32'h0F16_1C39;
    localparam logic [31:0] EXP_SAT_SUM = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_TW1     = 32'h1FD8_FCDD;
    localparam logic [31:0] EXP_TW5     = 32'h0F15_1C38;
    localparam logic [31:0] EXP_SAT_SUM = 32'hFFFF_FFFF;
`endif

    fft_sdf_stage #(.STAGE(0), .N_FFT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = 32'h0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        last_exp = 32'h0;
        chk({tag, " rst vld"}, 32'(out_valid), 32'h0);
        chk({tag, " rst dat"}, data_out, 32'h0);
    endtask

    // Scenarios: 0 impulse, 1 DC, 2 twiddle, 3 saturation. Two frames each.
    function automatic logic [31:0] stim(int sc, int f, int i);
        if (sc == 0 && f == 0 && i == 0)  return 32'h4000_0000;
        if (sc == 1)                      return 32'h03E8_0000;
        if (sc == 2 && f == 0 && i == 1)  return 32'h4000_0000;
        if (sc == 2 && f == 0 && i == 5)  return 32'h0000_4000;
        if (sc == 3 && f == 0 && i == 8)  return 32'h7FFF_7FFF;
        if (sc == 3 && f == 0 && i == 40) return 32'h8000_8000;
        return 32'h0;
    endfunction

    function automatic logic [31:0] expv(int sc, int f, int i);
        if (sc == 0 && ((f == 0 && i == 32) || (f == 1 && i == 0))) return 32'h2000_0000;
        if (sc == 1 && i >= 32)           return 32'h03E8_0000;
        if (sc == 2 && f == 0 && i == 33) return 32'h2000_0000;
        if (sc == 2 && f == 0 && i == 37) return 32'h0000_2000;
        if (sc == 2 && f == 1 && i == 1)  return EXP_TW1;
        if (sc == 2 && f == 1 && i == 5)  return EXP_TW5;
        if (sc == 3 && f == 0 && i == 40) return EXP_SAT_SUM;
        if (sc == 3 && f == 1 && i == 8)  return 32'h7FFF_0000;
        return 32'h0;
    endfunction

    task automatic run_two_frames(input int sc, input bit gaps);
        logic v;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) begin
                if (gaps) begin
                    repeat ($urandom_range(0, 2)) begin
                        step(1'b0, $urandom);
                        chk($sformatf("s%0d f%0d i%0d gap vld", sc, f, i), 32'(out_valid), 32'h0);
                        chk($sformatf("s%0d f%0d i%0d gap hold", sc, f, i), data_out, last_exp);
                    end
                end
                step(1'b1, stim(sc, f, i));
                v = !(f == 0 && i < 32);
                chk($sformatf("s%0d f%0d i%0d vld", sc, f, i), 32'(out_valid), 32'(v));
                if (v)
                    last_exp = expv(sc, f, i);
                chk($sformatf("s%0d f%0d i%0d dat", sc, f, i), data_out, last_exp);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        data_in  = 32'h0;
        @(posedge clk);
        #1;

        do_reset("impulse");
        run_two_frames(0, 1'b0);

        do_reset("dc");
        run_two_frames(1, 1'b0);

        do_reset("twiddle");
        run_two_frames(2, 1'b0);

        do_reset("sat");
        run_two_frames(3, 1'b0);

        do_reset("stall");
        run_two_frames(2, 1'b1);

        do_reset("midrst pre");
        for (int i = 0; i < 17; i++) begin
            step(1'b1, $urandom);
            chk($sformatf("midrst i%0d vld", i), 32'(out_valid), 32'h0);
        end
        do_reset("midrst");
        run_two_frames(0, 1'b0);

        step(1'b0, 32'h0);
        chk("idle vld", 32'(out_valid), 32'h0);
        chk("idle hold", data_out, last_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
